// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit-adjust helpers for the
// sequential BCD <-> binary converters.
package bcd_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int BCD_BIN_W  = 14;
  localparam int BCD_MAX    = 9999;
  localparam int BCD_CNT_W  = $clog2(BCD_BIN_W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [3:0] dab_sub3(
    input logic [3:0] d
  );
    return (d >= 4'd8) ? d - 4'd3 : d;
  endfunction

  // Forward double dabble rule, used by the binary-to-BCD variant.
  function automatic logic [3:0] dab_add3(
    input logic [3:0] d
  );
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// start/busy/done handshake bundle for the BCD-to-binary converter.
// The master drives the request; the slave is the converter.
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [BIN_W-1:0]      binary_out;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  error,
    input  binary_out
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output error,
    output binary_out
  );

endinterface

// File: rtl/bcd_digit_correct.sv
// Per-digit reverse double dabble adjust: subtract 3 when digit >= 8.
// Purely combinational, 4-bit arithmetic, no inter-digit carry.
module bcd_digit_correct
  import bcd_pkg::*;
(
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = dab_sub3(i_d);

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter, one reverse double dabble bit per clock.
// Optional invalid-digit check enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = BCD_DIGITS,
  parameter int BIN_W  = BCD_BIN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_to_binary_seq_if.slave   bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  state_t              r_state;
  logic [BCD_W-1:0]    r_bcd;
  logic [BIN_W-1:0]    r_bin;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [BIN_W-1:0]    r_out;

  logic [BCD_W-1:0]    w_bcd_sh;
  logic [BCD_W-1:0]    w_bcd_cor;
  logic [BIN_W-1:0]    w_bin_sh;

  // {bcd, bin} >> 1: bcd LSB falls into the bin MSB.
  assign w_bcd_sh = {1'b0, r_bcd[BCD_W-1:1]};
  assign w_bin_sh = {r_bcd[0], r_bin[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_correct u_cor (
      .i_d (w_bcd_sh[4*g +: 4]),
      .o_d (w_bcd_cor[4*g +: 4])
    );
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic w_bad;
  logic r_err;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      if (w_bad) r_err <= 1'b1;
    end else if (r_state == SHIFT &&
                 r_cnt == CNT_W'(BIN_W - 1)) begin
      r_err <= 1'b0;
    end
  end

  assign bus.error = r_err;
`else
  assign bus.error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
            if (w_bad) begin
              r_done  <= 1'b1;
              r_out   <= '0;
              r_state <= DONE;
            end else begin
              r_bcd   <= bus.bcd_in;
              r_bin   <= '0;
              r_cnt   <= '0;
              r_state <= SHIFT;
            end
`else
            r_bcd   <= bus.bcd_in;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_state <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_cor;
          r_bin <= w_bin_sh;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_out   <= w_bin_sh;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.binary_out = r_out;

endmodule
